// File: rtl/mpu_pkg.sv
// Shared constants, state encoding and element addressing for the MPU determinant datapath.
// The packed matrix is ascending [0:MATRIX_W-1]; element (r,c) occupies at(r,c) +: ELEM_W.
package mpu_pkg;

   localparam int DIM      = 5;
   localparam int ELEM_W   = 8;
   localparam int MATRIX_W = ELEM_W * DIM * DIM;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   function automatic int at(input logic [2:0] row, input logic [2:0] col);
      return ELEM_W * (int'(col) + DIM * int'(row));
   endfunction

endpackage

// File: rtl/mpu_rc_counter.sv
// Row/column walker for a square matrix whose dimension is chosen at run time.
// 'last' flags the bottom-right element so the owner can stop before the row counter overflows.
module mpu_rc_counter
   import mpu_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       inc,
   input  logic [2:0] bound,
   output logic [2:0] row,
   output logic [2:0] col,
   output logic       last
);

   logic col_end;

   assign col_end = (col == bound - 3'd1);
   assign last    = col_end && (row == bound - 3'd1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col_end) begin
            col <= '0;
            row <= row + 3'd1;
         end else begin
            col <= col + 3'd1;
         end
      end
   end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Collects a row-major byte stream into the packed 5x5 matrix consumed by the determinant stage.
// Matrix and size are held from the done pulse until the next accepted start.
module mpu_matrix_loader
   import mpu_pkg::*;
(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [7:0]          size,
   input  logic [ELEM_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [0:MATRIX_W-1] matrix,
   output logic [7:0]          matrix_size,
   output logic                busy,
   output logic                done,
   output logic                error
);

   state_t     state;
   logic [2:0] row;
   logic [2:0] col;
   logic       last;
   logic       size_ok;
   logic       accept;
   logic       load_start;

   // size is a signed byte: negative values must be rejected, not read as large positives
   assign size_ok    = (int'($signed(size)) >= 1) && (int'($signed(size)) <= DIM);
   assign load_start = (state == IDLE) && start && size_ok;
   assign accept     = (state == LOAD) && in_valid && in_ready;

   mpu_rc_counter u_rc (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (load_start),
      .inc     (accept),
      .bound   (matrix_size[2:0]),
      .row     (row),
      .col     (col),
      .last    (last)
   );

   // NOTE: all state and outputs below are registers; every assignment in this block is
   // non-blocking so each branch sees the pre-edge values of state, row, col and matrix.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         // NOTE: matrix is a flop array, not a RAM, so it takes the async reset like any other register.
         matrix      <= '0;
         matrix_size <= '0;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (size_ok) begin
                     matrix      <= '0;
                     matrix_size <= size;
                     in_ready    <= 1'b1;
                     busy        <= 1'b1;
                     state       <= LOAD;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  matrix[at(row, col) +: ELEM_W] <= in_data;
                  if (last) begin
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               in_ready <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader: latency, stalls, zero-fill, illegal sizes and mid-load reset.
// Stimulus changes and output sampling both happen on the falling clock edge.
module tb_mpu_matrix_loader;
   import mpu_pkg::*;

   logic                clock = 1'b0;
   logic                reset_n = 1'b0;
   logic                start = 1'b0;
   logic [7:0]          size = '0;
   logic [ELEM_W-1:0]   in_data = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [0:MATRIX_W-1] matrix;
   logic [7:0]          matrix_size;
   logic                busy;
   logic                done;
   logic                error;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [7:0]          vals [25];
   logic [0:MATRIX_W-1] exp_m;
   int                  done_cyc;
   int                  xfers;
   int                  busy_low;

   mpu_matrix_loader dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .size        (size),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .matrix      (matrix),
      .matrix_size (matrix_size),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clock = ~clock;

   // Expected matrix from vals[] laid out row-major for an sz x sz load, zero elsewhere.
   task automatic build_exp(input int sz);
      exp_m = '0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            if (r < sz && c < sz) exp_m[8*(c+5*r) +: 8] = vals[r*sz+c];
   endtask

   // Start a load and stream vals[]; cycle 1 is the first cycle after the start cycle.
   task automatic run_load(input logic [7:0] sz, input bit gaps, input int restart_cyc);
      int n;
      n = int'($signed(sz));
      @(negedge clock);
      start = 1'b1;
      size  = sz;
      @(negedge clock);
      start    = 1'b0;
      done_cyc = 0;
      xfers    = 0;
      busy_low = 0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (!busy) busy_low++;
         start    = (cyc == restart_cyc);
         size     = start ? 8'd2 : sz;
         in_valid = (xfers < n*n) && (!gaps || (cyc % 2 == 1));
         in_data  = (xfers < 25) ? vals[xfers] : 8'h00;
         if (in_valid && in_ready) xfers++;
         @(negedge clock);
      end
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      chk_cnt++;
      if ({in_ready, busy, done, error, matrix_size} !== 12'h000)
         $display("FAIL reset_ctrl: got %h expected 000", {in_ready, busy, done, error, matrix_size});
      else pass_cnt++;
      chk_cnt++;
      if (matrix !== '0) $display("FAIL reset_matrix: got %h expected 0", matrix);
      else pass_cnt++;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_size2();
      for (int i = 0; i < 4; i++) vals[i] = 8'(i + 1);
      run_load(8'd2, 1'b0, -1);
      build_exp(2);
      chk_cnt++;
      if (done_cyc !== 5) $display("FAIL size2_latency: got %0d expected 5", done_cyc);
      else pass_cnt++;
      chk_cnt++;
      if (xfers !== 4) $display("FAIL size2_transfers: got %0d expected 4", xfers);
      else pass_cnt++;
      chk_cnt++;
      if (matrix !== exp_m) $display("FAIL size2_matrix: got %h expected %h", matrix, exp_m);
      else pass_cnt++;
      chk_cnt++;
      if (matrix_size !== 8'd2) $display("FAIL size2_matrix_size: got %0d expected 2", matrix_size);
      else pass_cnt++;
      @(negedge clock);
      chk_cnt++;
      if ({done, busy, in_ready} !== 3'b000)
         $display("FAIL size2_done_pulse: got %b expected 000", {done, busy, in_ready});
      else pass_cnt++;
   endtask

   task automatic test_size5_gaps();
      for (int i = 0; i < 25; i++) vals[i] = 8'(i + 1);
      run_load(8'd5, 1'b1, -1);
      build_exp(5);
      chk_cnt++;
      if (xfers !== 25) $display("FAIL size5_transfers: got %0d expected 25", xfers);
      else pass_cnt++;
      chk_cnt++;
      if (done_cyc !== 50) $display("FAIL size5_latency: got %0d expected 50", done_cyc);
      else pass_cnt++;
      chk_cnt++;
      if (matrix[192 +: 8] !== 8'd25) $display("FAIL size5_elem44: got %h expected 19", matrix[192 +: 8]);
      else pass_cnt++;
      chk_cnt++;
      if (matrix !== exp_m) $display("FAIL size5_matrix: got %h expected %h", matrix, exp_m);
      else pass_cnt++;
      chk_cnt++;
      if (busy_low !== 0) $display("FAIL size5_busy: got %0d low cycles expected 0", busy_low);
      else pass_cnt++;
   endtask

   task automatic test_clear_on_start();
      for (int i = 0; i < 25; i++) vals[i] = 8'hFF;
      run_load(8'd5, 1'b0, -1);
      chk_cnt++;
      if (done_cyc !== 26) $display("FAIL ff_latency: got %0d expected 26", done_cyc);
      else pass_cnt++;
      for (int i = 0; i < 9; i++) vals[i] = 8'(10 + i);
      run_load(8'd3, 1'b0, -1);
      build_exp(3);
      chk_cnt++;
      if (done_cyc !== 10) $display("FAIL size3_latency: got %0d expected 10", done_cyc);
      else pass_cnt++;
      chk_cnt++;
      if (matrix !== exp_m) $display("FAIL size3_zero_fill: got %h expected %h", matrix, exp_m);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      logic [7:0] bad [3];
      bad = '{8'd0, 8'd6, 8'hFF};
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         start = 1'b1;
         size  = bad[k];
         @(negedge clock);
         start = 1'b0;
         chk_cnt++;
         if ({error, in_ready, busy} !== 3'b100)
            $display("FAIL error_pulse_%0d: got %b expected 100", k, {error, in_ready, busy});
         else pass_cnt++;
         @(negedge clock);
         chk_cnt++;
         if ({error, in_ready, busy} !== 3'b000)
            $display("FAIL error_clear_%0d: got %b expected 000", k, {error, in_ready, busy});
         else pass_cnt++;
         chk_cnt++;
         if (matrix !== exp_m || matrix_size !== 8'd3)
            $display("FAIL error_hold_%0d: got size %0d expected 3, matrix %h", k, matrix_size, matrix);
         else pass_cnt++;
      end
   endtask

   task automatic test_size1_neg();
      vals[0] = 8'h80;
      run_load(8'd1, 1'b0, -1);
      build_exp(1);
      chk_cnt++;
      if (done_cyc !== 2) $display("FAIL size1_latency: got %0d expected 2", done_cyc);
      else pass_cnt++;
      chk_cnt++;
      if (matrix[0:7] !== 8'h80) $display("FAIL size1_byte0: got %h expected 80", matrix[0:7]);
      else pass_cnt++;
      chk_cnt++;
      if (matrix !== exp_m) $display("FAIL size1_matrix: got %h expected %h", matrix, exp_m);
      else pass_cnt++;
   endtask

   task automatic test_start_during_load();
      for (int i = 0; i < 16; i++) vals[i] = 8'(21 + i);
      run_load(8'd4, 1'b0, 3);
      build_exp(4);
      chk_cnt++;
      if (xfers !== 16) $display("FAIL restart_transfers: got %0d expected 16", xfers);
      else pass_cnt++;
      chk_cnt++;
      if (done_cyc !== 17) $display("FAIL restart_latency: got %0d expected 17", done_cyc);
      else pass_cnt++;
      chk_cnt++;
      if (matrix_size !== 8'd4 || matrix !== exp_m)
         $display("FAIL restart_matrix: got size %0d expected 4, matrix %h expected %h", matrix_size, matrix, exp_m);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_load();
      int done_seen;
      for (int i = 0; i < 16; i++) vals[i] = 8'(50 + i);
      @(negedge clock);
      start = 1'b1;
      size  = 8'd4;
      @(negedge clock);
      start = 1'b0;
      xfers = 0;
      for (int cyc = 0; cyc < 50 && xfers < 7; cyc++) begin
         in_valid = 1'b1;
         in_data  = vals[xfers];
         if (in_ready) xfers++;
         @(negedge clock);
      end
      in_valid = 1'b0;
      chk_cnt++;
      if (xfers !== 7) $display("FAIL midreset_partial: got %0d expected 7", xfers);
      else pass_cnt++;
      reset_n = 1'b0;
      #1;
      chk_cnt++;
      if ({in_ready, busy, done, error, matrix_size} !== 12'h000 || matrix !== '0)
         $display("FAIL midreset_outputs: got ctrl %h expected 000, matrix %h",
                  {in_ready, busy, done, error, matrix_size}, matrix);
      else pass_cnt++;
      done_seen = 0;
      repeat (2) begin
         @(negedge clock);
         if (done) done_seen++;
      end
      reset_n  = 1'b1;
      in_valid = 1'b1;
      repeat (20) begin
         @(negedge clock);
         if (done || in_ready) done_seen++;
      end
      in_valid = 1'b0;
      chk_cnt++;
      if (done_seen !== 0) $display("FAIL midreset_no_done: got %0d expected 0", done_seen);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) vals[i] = 8'(5 + i);
      run_load(8'd2, 1'b0, -1);
      build_exp(2);
      chk_cnt++;
      if (done_cyc !== 5 || matrix !== exp_m)
         $display("FAIL post_reset_load: got done cycle %0d expected 5, matrix %h expected %h", done_cyc, matrix, exp_m);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_size2();
      test_size5_gaps();
      test_clear_on_start();
      test_errors();
      test_size1_neg();
      test_start_during_load();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
